// File: rtl/psram_lsu.sv
`default_nettype none
// ============================================================================
// Module   : psram_lsu
// Purpose  : Load/store unit bridging a 32-bit core memory port onto a
//            16-bit PSRAM controller. Each access is split into one (byte,
//            half) or two (word) 16-bit half-transactions, LO first.
//            The core is stalled until the one-cycle response pulse.
// Ports    : clk, reset_n (async, active-low)
//            req_valid/req_we/req_addr/req_wdata/req_size/req_unsigned - core request
//            stall, rsp_valid, rsp_rdata, rsp_err                  - core response
//            ps_addr, ps_write_en, ps_read_en, ps_data_in,
//            ps_write_high_byte, ps_write_low_byte                 - to controller
//            ps_busy, ps_read_avail, ps_data_out                   - from controller
// Config   : `define PSRAM_LSU_TIMEOUT_EN to compile in the per-half watchdog
//            (TIMEOUT_CYCLES wait cycles, then rsp_err=1 / 32'hDEAD_BEEF).
// Revision : 1.0 - initial release
// ============================================================================
module psram_lsu #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [21:0] ps_addr,
    output logic        ps_write_en,
    output logic        ps_read_en,
    output logic [15:0] ps_data_in,
    output logic        ps_write_high_byte,
    output logic        ps_write_low_byte,
    input  logic        ps_busy,
    input  logic        ps_read_avail,
    input  logic [15:0] ps_data_out
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE_LO = 3'd1,
        S_WAIT_LO  = 3'd2,
        S_ISSUE_HI = 3'd3,
        S_WAIT_HI  = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    localparam logic [31:0] c_err_data = 32'hDEAD_BEEF;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic        r_unsigned;
    logic [1:0]  r_size;
    logic [22:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_busy_seen;

    logic [22:0] w_aligned;
    logic        w_is_byte;
    logic        w_is_word;
    logic        w_issue;
    logic        w_fire;
    logic        w_wait;
    logic        w_hi_phase;
    logic        w_wait_done;
    logic        w_timeout;
    logic        w_err;
    logic [7:0]  w_byte;

    // Upper address bits are outside the PSRAM window.
    logic        w_unused;
    assign w_unused = ^req_addr[31:23];

    always_comb begin
        case (req_size)
            2'd0:    w_aligned = req_addr[22:0];
            2'd1:    w_aligned = {req_addr[22:1], 1'b0};
            default: w_aligned = {req_addr[22:2], 2'b00};
        endcase
    end

    assign w_is_byte  = (r_size == 2'd0);
    assign w_is_word  = r_size[1];           // sizes 2 and 3 are both words
    assign w_issue    = (r_state == S_ISSUE_LO) || (r_state == S_ISSUE_HI);
    assign w_fire     = w_issue && !ps_busy;
    assign w_wait     = (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);
    assign w_hi_phase = (r_state == S_ISSUE_HI) || (r_state == S_WAIT_HI);

    // A write is only complete once the controller has shown busy and then
    // released it; a read completes on the first data-valid cycle.
    assign w_wait_done = r_we ? (!ps_busy && r_busy_seen) : ps_read_avail;

`ifdef PSRAM_LSU_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [CW-1:0] r_cnt;
    logic          r_err;

    assign w_timeout = w_wait && !w_wait_done && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_err     = r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && req_valid) begin
                r_err <= 1'b0;
            end
            if (w_fire) begin
                r_cnt <= '0;
            end else if (w_wait) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_unsigned  <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_busy_seen <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req_valid) begin
                r_we       <= req_we;
                r_unsigned <= req_unsigned;
                r_size     <= req_size;
                r_addr     <= w_aligned;
                r_wdata    <= req_wdata;
                r_rdata    <= '0;
            end
            if (w_fire) begin
                r_busy_seen <= 1'b0;
            end else if (w_wait && ps_busy) begin
                r_busy_seen <= 1'b1;
            end
            if (w_wait && !r_we && ps_read_avail) begin
                if (w_hi_phase) begin
                    r_rdata[31:16] <= ps_data_out;
                end else begin
                    r_rdata[15:0] <= ps_data_out;
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (req_valid) w_next = S_ISSUE_LO;
            S_ISSUE_LO: if (!ps_busy) w_next = S_WAIT_LO;
            S_WAIT_LO: begin
                if (w_wait_done) begin
                    w_next = w_is_word ? S_ISSUE_HI : S_RESP;
                end else if (w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_ISSUE_HI: if (!ps_busy) w_next = S_WAIT_HI;
            S_WAIT_HI:  if (w_wait_done || w_timeout) w_next = S_RESP;
            S_RESP:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    assign stall = ((r_state != S_IDLE) && (r_state != S_RESP)) ||
                   ((r_state == S_IDLE) && req_valid);

    assign ps_read_en  = w_fire && !r_we;
    assign ps_write_en = w_fire && r_we;
    assign ps_addr     = w_hi_phase ? (r_addr[22:1] + 22'd1) : r_addr[22:1];

    always_comb begin
        ps_data_in = w_hi_phase ? r_wdata[31:16] : r_wdata[15:0];
        if (w_is_byte) begin
            ps_data_in = {r_wdata[7:0], r_wdata[7:0]};
        end
    end

    assign ps_write_high_byte = ps_write_en && (!w_is_byte || r_addr[0]);
    assign ps_write_low_byte  = ps_write_en && (!w_is_byte || !r_addr[0]);

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_err   = rsp_valid && w_err;
    assign w_byte    = r_addr[0] ? r_rdata[15:8] : r_rdata[7:0];

    always_comb begin
        rsp_rdata = '0;
        if (rsp_valid && !r_we) begin
            if (w_err) begin
                rsp_rdata = c_err_data;
            end else if (w_is_word) begin
                rsp_rdata = r_rdata;
            end else if (w_is_byte) begin
                rsp_rdata = {(r_unsigned ? 24'd0 : {24{w_byte[7]}}), w_byte};
            end else begin
                rsp_rdata = {(r_unsigned ? 16'd0 : {16{r_rdata[15]}}), r_rdata[15:0]};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psram_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_psram_lsu
// Purpose  : Directed self-checking bench for psram_lsu. The bench plays the
//            PSRAM controller by hand, stepping on falling edges and
//            sampling 1 ns after each drive.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psram_lsu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [21:0] ps_addr;
    logic        ps_write_en;
    logic        ps_read_en;
    logic [15:0] ps_data_in;
    logic        ps_write_high_byte;
    logic        ps_write_low_byte;
    logic        ps_busy;
    logic        ps_read_avail;
    logic [15:0] ps_data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psram_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .req_valid          (req_valid),
        .req_we             (req_we),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .req_size           (req_size),
        .req_unsigned       (req_unsigned),
        .stall              (stall),
        .rsp_valid          (rsp_valid),
        .rsp_rdata          (rsp_rdata),
        .rsp_err            (rsp_err),
        .ps_addr            (ps_addr),
        .ps_write_en        (ps_write_en),
        .ps_read_en         (ps_read_en),
        .ps_data_in         (ps_data_in),
        .ps_write_high_byte (ps_write_high_byte),
        .ps_write_low_byte  (ps_write_low_byte),
        .ps_busy            (ps_busy),
        .ps_read_avail      (ps_read_avail),
        .ps_data_out        (ps_data_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [1:0] size, input logic uns);
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_wdata = wd; req_size = size; req_unsigned = uns;
    endtask

    // Complete load; lo_addr is the expected LO word address.
    task automatic load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [15:0] lo, input logic [15:0] hi,
                        input logic [21:0] lo_addr, input logic [31:0] exp);
        @(negedge clk); drive_req(1'b0, addr, 32'h0, size, uns); #1;
        chk({tag, " stall_idle"}, stall, 1);
        @(negedge clk); #1;
        chk({tag, " rd_en_lo"}, ps_read_en, 1);
        chk({tag, " addr_lo"}, ps_addr, lo_addr);
        @(negedge clk); ps_read_avail = 1'b1; ps_data_out = lo; #1;
        chk({tag, " rd_en_wait"}, ps_read_en, 0);
        chk({tag, " stall_wait"}, stall, 1);
        if (size >= 2'd2) begin
            @(negedge clk); ps_read_avail = 1'b0; #1;
            chk({tag, " rd_en_hi"}, ps_read_en, 1);
            chk({tag, " addr_hi"}, ps_addr, lo_addr + 22'd1);
            @(negedge clk); ps_read_avail = 1'b1; ps_data_out = hi;
        end
        @(negedge clk); ps_read_avail = 1'b0; req_valid = 1'b0; #1;
        chk({tag, " rsp_valid"}, rsp_valid, 1);
        chk({tag, " rdata"}, rsp_rdata, exp);
        chk({tag, " stall_resp"}, stall, 0);
        chk({tag, " rsp_err"}, rsp_err, 0);
        @(negedge clk); #1;
        chk({tag, " rsp_gone"}, rsp_valid, 0);
    endtask

    // Complete store with a busy-high / busy-low handshake on each half.
    task automatic store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wd, input logic [21:0] lo_addr,
                         input logic [15:0] din_lo, input logic hi_en, input logic lo_en);
        @(negedge clk); drive_req(1'b1, addr, wd, size, 1'b0);
        @(negedge clk); #1;
        chk({tag, " wr_en_lo"}, ps_write_en, 1);
        chk({tag, " addr_lo"}, ps_addr, lo_addr);
        chk({tag, " din_lo"}, ps_data_in, din_lo);
        chk({tag, " hi_en"}, ps_write_high_byte, hi_en);
        chk({tag, " lo_en"}, ps_write_low_byte, lo_en);
        @(negedge clk); ps_busy = 1'b1; #1;
        chk({tag, " wr_single"}, ps_write_en, 0);
        @(negedge clk); ps_busy = 1'b0;
        if (size >= 2'd2) begin
            @(negedge clk); #1;
            chk({tag, " wr_en_hi"}, ps_write_en, 1);
            chk({tag, " addr_hi"}, ps_addr, lo_addr + 22'd1);
            chk({tag, " din_hi"}, ps_data_in, wd[31:16]);
            @(negedge clk); ps_busy = 1'b1;
            @(negedge clk); ps_busy = 1'b0;
        end
        @(negedge clk); req_valid = 1'b0; #1;
        chk({tag, " rsp_valid"}, rsp_valid, 1);
        chk({tag, " rdata_zero"}, rsp_rdata, 0);
        chk({tag, " stall_resp"}, stall, 0);
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_size = '0; req_unsigned = 1'b0;
        ps_busy = 1'b0; ps_read_avail = 1'b0; ps_data_out = '0;
        #2;
        chk("rst stall", stall, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_err", rsp_err, 0);
        chk("rst ps_addr", ps_addr, 0);
        chk("rst ps_data_in", ps_data_in, 0);
        chk("rst rsp_rdata", rsp_rdata, 0);
        chk("rst cmds", {ps_write_en, ps_read_en, ps_write_high_byte, ps_write_low_byte}, 0);
        @(negedge clk); reset_n = 1'b1;

        load("wload", 32'h0000_0104, 2'd2, 1'b0, 16'h5678, 16'h1234, 22'h82, 32'h1234_5678);
        load("bload_s", 32'h0000_0003, 2'd0, 1'b0, 16'h80FF, 16'h0, 22'h1, 32'hFFFF_FF80);
        load("bload_u", 32'h0000_0003, 2'd0, 1'b1, 16'h80FF, 16'h0, 22'h1, 32'h0000_0080);
        load("bload_e", 32'h0000_0002, 2'd0, 1'b0, 16'h80FF, 16'h0, 22'h1, 32'hFFFF_FFFF);
        load("hload_s", 32'h0000_0007, 2'd1, 1'b0, 16'h8001, 16'h0, 22'h3, 32'hFFFF_8001);
        load("hload_u", 32'h0000_0007, 2'd1, 1'b1, 16'h8001, 16'h0, 22'h3, 32'h0000_8001);
        load("wload_s3", 32'h0000_0013, 2'd3, 1'b0, 16'hBEEF, 16'hCAFE, 22'h8, 32'hCAFE_BEEF);

        store("bstore", 32'h0000_0010, 2'd0, 32'h0000_00AB, 22'h8, 16'hABAB, 1'b0, 1'b1);
        store("bstore_o", 32'h0000_0011, 2'd0, 32'h0000_00CD, 22'h8, 16'hCDCD, 1'b1, 1'b0);
        store("hstore", 32'h0000_0021, 2'd1, 32'h9999_1357, 22'h10, 16'h1357, 1'b1, 1'b1);
        store("wstore", 32'h0000_0102, 2'd2, 32'h1122_3344, 22'h80, 16'h3344, 1'b1, 1'b1);

        // Busy held at ISSUE_LO: no command until busy drops, then one pulse.
        @(negedge clk); drive_req(1'b0, 32'h0000_0020, 32'h0, 2'd0, 1'b1); ps_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("busy hold rd_en", ps_read_en, 0);
            chk("busy hold stall", stall, 1);
        end
        @(negedge clk); ps_busy = 1'b0; #1;
        chk("busy drop rd_en", ps_read_en, 1);
        chk("busy drop addr", ps_addr, 22'h10);
        @(negedge clk); #1;
        chk("busy single pulse", ps_read_en, 0);
        ps_read_avail = 1'b1; ps_data_out = 16'h7742;
        @(negedge clk); ps_read_avail = 1'b0; req_valid = 1'b0; #1;
        chk("busy rsp_valid", rsp_valid, 1);
        chk("busy rdata", rsp_rdata, 32'h0000_0042);

        // Reset during WAIT_HI of a word store.
        @(negedge clk); drive_req(1'b1, 32'h0000_0200, 32'hCAFE_BABE, 2'd2, 1'b0);
        @(negedge clk);
        @(negedge clk); ps_busy = 1'b1;
        @(negedge clk); ps_busy = 1'b0;
        @(negedge clk); #1;
        chk("rst_mid wr_en_hi", ps_write_en, 1);
        chk("rst_mid addr_hi", ps_addr, 22'h101);
        @(negedge clk); ps_busy = 1'b1; #1;
        reset_n = 1'b0; req_valid = 1'b0; #1;
        chk("rst_mid stall", stall, 0);
        chk("rst_mid rsp_valid", rsp_valid, 0);
        chk("rst_mid ps_addr", ps_addr, 0);
        chk("rst_mid ps_data_in", ps_data_in, 0);
        chk("rst_mid cmds", {ps_write_en, ps_read_en, ps_write_high_byte, ps_write_low_byte}, 0);
        ps_busy = 1'b0;
        @(negedge clk); #1;
        chk("rst_mid no rsp", rsp_valid, 0);
        reset_n = 1'b1;
        load("post_rst", 32'h0000_0003, 2'd0, 1'b0, 16'h80FF, 16'h0, 22'h1, 32'hFFFF_FF80);

`ifdef PSRAM_LSU_TIMEOUT_EN
        begin
            int n;
            n = 0;
            @(negedge clk); drive_req(1'b0, 32'h0000_0040, 32'h0, 2'd0, 1'b0);
            @(negedge clk); #1;
            chk("to rd_en", ps_read_en, 1);
            while (n < 40 && !rsp_valid) begin
                @(negedge clk); #1;
                n++;
            end
            req_valid = 1'b0;
            chk("to latency", n, 9);
            chk("to rsp_valid", rsp_valid, 1);
            chk("to rsp_err", rsp_err, 1);
            chk("to rdata", rsp_rdata, 32'hDEAD_BEEF);
            @(negedge clk); #1;
            chk("to idle", stall, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psram_lsu.md
PSRAM_LSU -- requirements
Module: psram_lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023, maximum wait cycles per half-transaction when the watchdog is compiled in.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  core memory request present, held while stall=1.
REQ-005 req_we  in  1  1=store, 0=load.
REQ-006 req_addr  in  32  byte address; bits [22:0] used.
REQ-007 req_wdata  in  32  store data.
REQ-008 req_size  in  2  0=byte, 1=half, 2=word; 3 treated as word.
REQ-009 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 stall  out  1  freezes core pipeline.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  32  extended load data; 0 for stores.
REQ-013 rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-014 ps_addr  out  22  16-bit word address to psram controller.
REQ-015 ps_write_en / ps_read_en  out  1 each  single-cycle command pulses.
REQ-016 ps_data_in  out  16  write data.
REQ-017 ps_write_high_byte / ps_write_low_byte  out  1 each  byte enables.
REQ-018 ps_busy  in  1  controller busy.
REQ-019 ps_read_avail  in  1  ps_data_out valid this cycle.
REQ-020 ps_data_out  in  16  read data.

Function
REQ-021 States: IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, RESP.
REQ-022 IDLE: req_valid=1 captures the request into registers and enters ISSUE_LO next edge; req_* are ignored in all other states.
REQ-023 stall = (state not in {IDLE, RESP}) or (state=IDLE and req_valid=1); stall=0 in RESP.
REQ-024 Alignment: half forces addr[0]=0; word forces addr[1:0]=0; no misalignment error is raised.
REQ-025 ISSUE_x: the command is pulsed for exactly one cycle only when ps_busy=0, then the FSM moves to WAIT_x; while ps_busy=1 the FSM holds with the command low.
REQ-026 LO half-transaction: ps_addr=addr[22:1]. HI half-transaction: ps_addr=addr[22:1]+1, wrapping modulo 2^22.
REQ-027 Byte store: ps_data_in={wdata[7:0],wdata[7:0]}; high enable=addr[0]; low enable=~addr[0].
REQ-028 Half store, and the LO half of a word store: ps_data_in=wdata[15:0], both enables set. Word store HI half: ps_data_in=wdata[31:16], both enables set.
REQ-029 Read WAIT_x: the first cycle with ps_read_avail=1 latches ps_data_out (LO into [15:0], HI into [31:16]); the latch cycle advances the FSM.
REQ-030 Write WAIT_x: completes on the first cycle ps_busy=0 after ps_busy has been sampled 1 since the issue.
REQ-031 WAIT_LO exits to ISSUE_HI for word accesses and to RESP otherwise; WAIT_HI exits to RESP.
REQ-032 RESP: rsp_valid=1 for one cycle, then IDLE. A request is accepted no earlier than the following IDLE cycle.
REQ-033 Load extension: byte selects [15:8] if addr[0] else [7:0], extended to 32 bits per req_unsigned; half is extended from [15:0]; word is passed through unchanged.
REQ-034 ps_read_avail or ps_busy edges arriving outside WAIT states are ignored.

Reset
REQ-035 reset_n low asynchronously forces IDLE; stall, rsp_valid, rsp_err, ps_write_en, ps_read_en, enables = 0; ps_addr, ps_data_in, rsp_rdata = 0.
REQ-036 Reset mid-transaction abandons it without a response; the first post-reset cycle behaves as IDLE.

Configuration
REQ-037 Macro PSRAM_LSU_TIMEOUT_EN defined:
  - a counter cleared on entry to each WAIT state increments per WAIT cycle;
  - reaching TIMEOUT_CYCLES jumps to RESP with rsp_err=1 and rsp_rdata=32'hDEAD_BEEF.
REQ-038 Macro undefined: no counter; rsp_err is tied 0; WAIT states hold indefinitely.

Verification
REQ-039 Word load at 0x0000_0104; controller returns 0x5678 then 0x1234 -> ps_addr 0x82 then 0x83, rsp_rdata=0x1234_5678, stall high until the RESP cycle.
REQ-040 Signed byte load at 0x0000_0003 with ps_data_out=0x80FF -> rsp_rdata=0xFFFF_FF80; unsigned variant -> 0x0000_0080.
REQ-041 Byte store of 0xAB at 0x0000_0010 -> ps_addr 0x8, ps_data_in 0xABAB, low enable=1, high enable=0, single write pulse, rsp_rdata=0.
REQ-042 ps_busy held 1 for 5 cycles at ISSUE_LO -> no command pulse during those cycles, exactly one pulse after busy drops.
REQ-043 With PSRAM_LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, read_avail never asserted -> RESP 8 cycles after WAIT_LO entry, rsp_err=1, rsp_rdata=0xDEAD_BEEF.
REQ-044 reset_n pulsed low during WAIT_HI of a word store -> outputs reset immediately, no rsp_valid, and a new request is accepted on the next cycle.
